// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, mode values and count limit for the two-mode timer.
package timer_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;
   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;
   localparam logic [7:0] MAX_COUNT_DEFAULT = 8'd99;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..PRESCALE-1 divider; Tick flags the terminal-count cycle so the
// consumer can register its own pulse and datapath update on the same edge.
module tick_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Enable,
   input  logic SyncClear,
   output logic Tick
);
   localparam int W = $clog2(PRESCALE);
   logic [W-1:0] cnt;
   assign Tick = Enable && !SyncClear && cnt == W'(PRESCALE - 1);
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) cnt <= '0;
      else if (SyncClear) cnt <= '0;
      else if (Enable) cnt <= Tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/two_mode_timer_core.sv
// two_mode_timer_core: stopwatch (wrapping up-count) or countdown (expires at zero) timer core
// whose Count feeds an 8-bit binary-to-BCD converter, so it never exceeds MAX_COUNT.
module two_mode_timer_core
   import timer_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int TICK_HZ     = 1,
   parameter int MAX_COUNT   = int'(MAX_COUNT_DEFAULT)
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Mode,
   input  logic       StartStop,
   input  logic       Clear,
   input  logic       Load,
   input  logic [7:0] LoadValue,
   output logic [7:0] Count,
   output logic       Running,
   output logic       Expired,
   output logic       TickOut
);
   localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
   localparam logic [7:0] MAX = 8'(MAX_COUNT);
   state_t state;
   logic mode_latched, tick, last_down;
   logic [7:0] load_val;
   assign load_val  = (LoadValue > MAX) ? MAX : LoadValue;
   assign last_down = mode_latched == MODE_DOWN && Count <= 8'd1;
   assign Running   = state == RUN;
   assign Expired   = state == DONE;
   // IDLE/DONE keep the prescaler at zero so every fresh start gets a full first period
   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Enable   (state == RUN),
      .SyncClear(Clear || state == IDLE || state == DONE),
      .Tick     (tick)
   );
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         Count        <= 8'd0;
         mode_latched <= MODE_UP;
         TickOut      <= 1'b0;
      end else begin
         TickOut <= tick;
         if (state == IDLE) mode_latched <= Mode;
         if (Clear) begin
            state <= IDLE;
            Count <= 8'd0;
         end else if (Load && state != RUN) begin
            state <= (state == DONE) ? IDLE : state;
            Count <= load_val;
         end else begin
            case (state)
               IDLE:  if (StartStop && !(Mode == MODE_DOWN && Count == 8'd0)) state <= RUN;
               RUN: begin
                  if (tick)
                     Count <= (mode_latched == MODE_DOWN) ? (last_down ? 8'd0 : Count - 8'd1)
                                                          : ((Count >= MAX) ? 8'd0 : Count + 8'd1);
                  if (tick && last_down) state <= DONE;
                  else if (StartStop) state <= PAUSE;
               end
               PAUSE: if (StartStop) state <= RUN;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_two_mode_timer_core.sv
// tb_two_mode_timer_core: scoreboard bench; each expected tick (value and cycle) is queued when
// the stimulus that causes it is driven and checked when TickOut fires.
module tb_two_mode_timer_core;
   logic       Clk, Reset_n, Mode, StartStop, Clear, Load;
   logic [7:0] LoadValue, Count;
   logic       Running, Expired, TickOut;
   int n_cmp = 0, n_bad = 0, cyc = 0;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   two_mode_timer_core #(.CLK_FREQ_HZ(4), .TICK_HZ(1), .MAX_COUNT(99)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Mode(Mode), .StartStop(StartStop), .Clear(Clear),
      .Load(Load), .LoadValue(LoadValue), .Count(Count), .Running(Running),
      .Expired(Expired), .TickOut(TickOut)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (TickOut === 1'b1) begin
         exp_t e;
         if (exp_q.size() == 0) check("tick_unexpected", 32'(Count), 999);
         else begin
            e = exp_q.pop_front();
            check("tick_count", 32'(Count), 32'(e.val));
            check("tick_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic pulse(input logic c, input logic l, input logic s, input logic [7:0] v);
      @(posedge Clk);
      #1;
      Clear = c; Load = l; StartStop = s; LoadValue = v;
      @(posedge Clk);
      #1;
      Clear = 1'b0; Load = 1'b0; StartStop = 1'b0;
   endtask

   task automatic exp_tick(input logic [7:0] v, input int k);
      exp_t e;
      e.val = v;
      e.cyc = cyc + k;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic outs(input string tag, input logic [7:0] c, input logic r, input logic e);
      check({tag, "_count"}, 32'(Count), 32'(c));
      check({tag, "_running"}, 32'(Running), 32'(r));
      check({tag, "_expired"}, 32'(Expired), 32'(e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      Reset_n = 1'b0; Mode = 1'b0; StartStop = 1'b0; Clear = 1'b0; Load = 1'b0; LoadValue = 8'd0;
      repeat (3) @(negedge Clk);
      outs("reset", 8'd0, 1'b0, 1'b0);
      check("reset_tick", 32'(TickOut), 0);
      @(posedge Clk);
      #1 Reset_n = 1'b1;

      // stopwatch wrap through MAX_COUNT
      Mode = 1'b0;
      pulse(1'b0, 1'b1, 1'b0, 8'd97);
      @(negedge Clk) outs("sw_load", 8'd97, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd98, 4); exp_tick(8'd99, 8); exp_tick(8'd0, 12); exp_tick(8'd1, 16);
      drain(30);
      outs("sw_run", 8'd1, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge Clk) outs("sw_clr", 8'd0, 1'b0, 1'b0);

      // countdown to expiry, StartStop ignored in DONE, Load leaves DONE
      Mode = 1'b1;
      pulse(1'b0, 1'b1, 1'b0, 8'd3);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd2, 4); exp_tick(8'd1, 8); exp_tick(8'd0, 12);
      drain(30);
      @(negedge Clk) outs("cd_done", 8'd0, 1'b0, 1'b1);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      repeat (10) @(posedge Clk);
      @(negedge Clk) outs("cd_hold", 8'd0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0, 8'd5);
      @(negedge Clk) outs("cd_reload", 8'd5, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 8'd0);

      // pause with prescaler at 2, resume ticks after exactly 2 cycles
      pulse(1'b0, 1'b1, 1'b0, 8'd10);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd9, 4);
      repeat (4) @(posedge Clk);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      repeat (20) @(posedge Clk);
      @(negedge Clk) outs("pause_hold", 8'd9, 1'b0, 1'b0);
      check("pause_queue", exp_q.size(), 0);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd8, 2);
      drain(10);
      outs("resume", 8'd8, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 8'd0);

      // countdown start at zero is ignored
      repeat (2) @(posedge Clk);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      repeat (6) @(posedge Clk);
      @(negedge Clk) outs("cd_zero", 8'd0, 1'b0, 1'b0);

      // clamp, Load ignored in RUN, Mode change in RUN ignored
      Mode = 1'b0;
      pulse(1'b0, 1'b1, 1'b0, 8'd200);
      @(negedge Clk) outs("clamp", 8'd99, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 8'd10);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd11, 4); exp_tick(8'd12, 8);
      Mode = 1'b1;
      pulse(1'b0, 1'b1, 1'b0, 8'd50);
      drain(20);
      outs("guard", 8'd12, 1'b1, 1'b0);
      Mode = 1'b0;
      pulse(1'b1, 1'b0, 1'b0, 8'd0);

      // Clear beats Load and StartStop
      pulse(1'b0, 1'b1, 1'b0, 8'd40);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd41, 4); exp_tick(8'd42, 8);
      drain(20);
      pulse(1'b1, 1'b1, 1'b1, 8'd77);
      @(negedge Clk) outs("prio", 8'd0, 1'b0, 1'b0);
      repeat (8) @(posedge Clk);
      @(negedge Clk) outs("prio_hold", 8'd0, 1'b0, 1'b0);

      // async reset mid-cycle while running
      pulse(1'b0, 1'b1, 1'b0, 8'd56);
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd57, 4);
      drain(10);
      @(posedge Clk);
      #3 Reset_n = 1'b0;
      #1;
      outs("async_rst", 8'd0, 1'b0, 1'b0);
      check("async_rst_tick", 32'(TickOut), 0);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      pulse(1'b0, 1'b0, 1'b1, 8'd0);
      exp_tick(8'd1, 4);
      drain(10);
      outs("post_rst", 8'd1, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 8'd0);
      repeat (3) @(posedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
